tcbus_monitor: RTL and testbench

TCBUS_MONITOR -- requirements
Module: tcbus_monitor

---
 rtl/tcbus_monitor.sv | 153 +++++++++++++++
 tb/tb_tcbus_monitor.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tcbus_monitor.sv
`default_nettype none
// ============================================================================
// Module   : tcbus_monitor
// Purpose  : Passive TC-bus protocol checker: outstanding-transaction counters,
//            request stability checks, watchdogs and sticky error reporting.
// Revision : 1.0 - initial release
// ============================================================================
module tcbus_monitor #(
  parameter int TC_AWIDTH     = 8,
  parameter int TC_DWIDTH     = 8,
  parameter int MAX_OUTST     = 4,
  parameter int TIMEOUT       = 16,
  parameter int RD_SAME_CYCLE = 0
) (
  input  logic                 clk_bus,
  input  logic                 rst_n,
  input  logic                 tc_req,
  input  logic                 tc_rnw,
  input  logic [TC_AWIDTH-1:0] tc_addr,
  input  logic [TC_DWIDTH-1:0] tc_wdata,
  input  logic                 tc_aack,
  input  logic                 tc_rack,
  input  logic                 tc_wack,
  input  logic                 err_clr,
  output logic [3:0]           rd_pending,
  output logic [3:0]           wr_pending,
  output logic [8:0]           err_flags,
  output logic [3:0]           err_first,
  output logic                 err_irq
);

  localparam logic [3:0] C_MAX     = 4'(MAX_OUTST);
  localparam logic [7:0] C_TMO     = 8'(TIMEOUT);
  localparam logic [7:0] C_TMO_M1  = 8'(TIMEOUT - 1);
  localparam logic [3:0] C_NONE    = 4'hF;
  localparam logic       C_RD_SAME = (RD_SAME_CYCLE != 0);

  logic                 r_prev_req;
  logic                 r_prev_aack;
  logic                 r_prev_rnw;
  logic [TC_AWIDTH-1:0] r_prev_addr;
  logic [TC_DWIDTH-1:0] r_prev_wdata;
  logic                 r_hist_vld;
  logic [7:0]           r_wd_aack;
  logic [7:0]           r_wd_rd;
  logic [7:0]           r_wd_wr;

  logic       w_rd_acc;
  logic       w_wr_acc;
  logic [4:0] w_total;
  logic       w_ovf;
  logic       w_stall;
  logic       w_aack_run;
  logic       w_rd_run;
  logic       w_wr_run;
  logic [8:0] w_new_err;
  logic [3:0] w_new_first;
  logic [3:0] w_rd_nxt;
  logic [3:0] w_wr_nxt;
  logic [8:0] w_flags_nxt;
  logic [3:0] w_first_nxt;
  logic [7:0] w_wd_aack_nxt;
  logic [7:0] w_wd_rd_nxt;
  logic [7:0] w_wd_wr_nxt;

  always_comb begin
    w_rd_acc   = tc_req & tc_aack & tc_rnw;
    w_wr_acc   = tc_req & tc_aack & ~tc_rnw;
    w_total    = {1'b0, rd_pending} + {1'b0, wr_pending};
    w_ovf      = (w_rd_acc | w_wr_acc) & (w_total == {1'b0, C_MAX}) & ~tc_rack & ~tc_wack;
    // A request left waiting for aack in the previous cycle must stay stable
    w_stall    = r_hist_vld & r_prev_req & ~r_prev_aack;
    w_aack_run = tc_req & ~tc_aack;
    w_rd_run   = (rd_pending != 4'd0) & ~tc_rack;
    w_wr_run   = (wr_pending != 4'd0) & ~tc_wack;

    w_new_err    = '0;
    w_new_err[0] = w_ovf;
    w_new_err[1] = tc_rack & (rd_pending == 4'd0) & ~(C_RD_SAME & w_rd_acc);
    w_new_err[2] = tc_wack & (wr_pending == 4'd0) & ~w_wr_acc;
    w_new_err[3] = w_stall & ~tc_req;
    w_new_err[4] = w_stall & (tc_addr != r_prev_addr);
    w_new_err[5] = w_stall & (tc_rnw != r_prev_rnw);
    w_new_err[6] = w_stall & ~r_prev_rnw & (tc_wdata != r_prev_wdata);
    w_new_err[7] = w_aack_run & (r_wd_aack == C_TMO_M1);
    w_new_err[8] = (w_rd_run & (r_wd_rd == C_TMO_M1)) | (w_wr_run & (r_wd_wr == C_TMO_M1));

    w_new_first = C_NONE;
    for (int i = 8; i >= 0; i--) begin
      if (w_new_err[i]) w_new_first = 4'(i);
    end

    w_rd_nxt = rd_pending;
    if (w_rd_acc & ~tc_rack & ~w_ovf & (rd_pending < C_MAX))
      w_rd_nxt = rd_pending + 4'd1;
    else if (~w_rd_acc & tc_rack & (rd_pending != 4'd0))
      w_rd_nxt = rd_pending - 4'd1;

    w_wr_nxt = wr_pending;
    if (w_wr_acc & ~tc_wack & ~w_ovf & (wr_pending < C_MAX))
      w_wr_nxt = wr_pending + 4'd1;
    else if (~w_wr_acc & tc_wack & (wr_pending != 4'd0))
      w_wr_nxt = wr_pending - 4'd1;

    if (err_clr) begin
      w_flags_nxt = w_new_err;
      w_first_nxt = w_new_first;
    end else begin
      w_flags_nxt = err_flags | w_new_err;
      w_first_nxt = (err_flags == 9'd0) ? w_new_first : err_first;
    end

    w_wd_aack_nxt = ~w_aack_run ? 8'd0 : ((r_wd_aack == C_TMO) ? C_TMO : r_wd_aack + 8'd1);
    w_wd_rd_nxt   = ~w_rd_run   ? 8'd0 : ((r_wd_rd   == C_TMO) ? C_TMO : r_wd_rd   + 8'd1);
    w_wd_wr_nxt   = ~w_wr_run   ? 8'd0 : ((r_wd_wr   == C_TMO) ? C_TMO : r_wd_wr   + 8'd1);
  end

  always_ff @(posedge clk_bus or negedge rst_n) begin
    if (!rst_n) begin
      rd_pending   <= 4'd0;
      wr_pending   <= 4'd0;
      err_flags    <= 9'd0;
      err_first    <= C_NONE;
      err_irq      <= 1'b0;
      r_prev_req   <= 1'b0;
      r_prev_aack  <= 1'b0;
      r_prev_rnw   <= 1'b0;
      r_prev_addr  <= '0;
      r_prev_wdata <= '0;
      r_hist_vld   <= 1'b0;
      r_wd_aack    <= 8'd0;
      r_wd_rd      <= 8'd0;
      r_wd_wr      <= 8'd0;
    end else begin
      rd_pending   <= w_rd_nxt;
      wr_pending   <= w_wr_nxt;
      err_flags    <= w_flags_nxt;
      err_first    <= w_first_nxt;
      err_irq      <= |w_flags_nxt;
      r_prev_req   <= tc_req;
      r_prev_aack  <= tc_aack;
      r_prev_rnw   <= tc_rnw;
      r_prev_addr  <= tc_addr;
      r_prev_wdata <= tc_wdata;
      r_hist_vld   <= 1'b1;
      r_wd_aack    <= w_wd_aack_nxt;
      r_wd_rd      <= w_wd_rd_nxt;
      r_wd_wr      <= w_wd_wr_nxt;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_tcbus_monitor.sv
`default_nettype none
// ============================================================================
// Module   : tb_tcbus_monitor
// Purpose  : Scoreboard bench for two tcbus_monitor configurations driven by
//            the same directed and random bus traffic.
// Revision : 1.0 - initial release
// ============================================================================
module tb_tcbus_monitor;

  localparam int MAXO = 4;

  logic       clk_bus = 1'b0;
  logic       rst_n   = 1'b0;
  logic       tc_req  = 1'b0;
  logic       tc_rnw  = 1'b0;
  logic [7:0] tc_addr = 8'd0;
  logic [7:0] tc_wdata = 8'd0;
  logic       tc_aack = 1'b0;
  logic       tc_rack = 1'b0;
  logic       tc_wack = 1'b0;
  logic       err_clr = 1'b0;

  logic [3:0] rd_p [2];
  logic [3:0] wr_p [2];
  logic [8:0] flags[2];
  logic [3:0] first[2];
  logic       irq  [2];

  int checks = 0;
  int errors = 0;

  always #5 clk_bus = ~clk_bus;

  tcbus_monitor #(.TC_AWIDTH(8), .TC_DWIDTH(8), .MAX_OUTST(MAXO), .TIMEOUT(16), .RD_SAME_CYCLE(0)) u0 (
    .clk_bus(clk_bus), .rst_n(rst_n), .tc_req(tc_req), .tc_rnw(tc_rnw), .tc_addr(tc_addr),
    .tc_wdata(tc_wdata), .tc_aack(tc_aack), .tc_rack(tc_rack), .tc_wack(tc_wack), .err_clr(err_clr),
    .rd_pending(rd_p[0]), .wr_pending(wr_p[0]), .err_flags(flags[0]), .err_first(first[0]), .err_irq(irq[0]));

  tcbus_monitor #(.TC_AWIDTH(8), .TC_DWIDTH(8), .MAX_OUTST(MAXO), .TIMEOUT(4), .RD_SAME_CYCLE(1)) u1 (
    .clk_bus(clk_bus), .rst_n(rst_n), .tc_req(tc_req), .tc_rnw(tc_rnw), .tc_addr(tc_addr),
    .tc_wdata(tc_wdata), .tc_aack(tc_aack), .tc_rack(tc_rack), .tc_wack(tc_wack), .err_clr(err_clr),
    .rd_pending(rd_p[1]), .wr_pending(wr_p[1]), .err_flags(flags[1]), .err_first(first[1]), .err_irq(irq[1]));

  typedef struct packed {
    logic [3:0] rd;
    logic [3:0] wr;
    logic [8:0] fl;
    logic [3:0] first;
    logic       irq;
  } obs_t;

  typedef struct {
    int         rd;
    int         wr;
    logic [8:0] fl;
    int         first;
    int         run_a;
    int         run_r;
    int         run_w;
    logic       p_req;
    logic       p_aack;
    logic       p_rnw;
    logic [7:0] p_addr;
    logic [7:0] p_wdata;
    logic       hist;
  } mstate_t;

  mstate_t m[2];
  int      tmo [2] = '{16, 4};
  logic    same[2] = '{1'b0, 1'b1};
  obs_t    q0[$];
  obs_t    q1[$];

  function automatic int lowest(input logic [8:0] e);
    for (int i = 0; i < 9; i++) if (e[i]) return i;
    return 15;
  endfunction

  function automatic obs_t mobs(input int k);
    obs_t o;
    o.rd    = 4'(m[k].rd);
    o.wr    = 4'(m[k].wr);
    o.fl    = m[k].fl;
    o.first = 4'(m[k].first);
    o.irq   = |m[k].fl;
    return o;
  endfunction

  function automatic obs_t dobs(input int k);
    obs_t o;
    o.rd    = rd_p[k];
    o.wr    = wr_p[k];
    o.fl    = flags[k];
    o.first = first[k];
    o.irq   = irq[k];
    return o;
  endfunction

  // Reference model: one call per sampled clock edge, using the current inputs
  task automatic model_step(input int k);
    logic [8:0] e;
    logic racc, wacc, ovf, stall;
    int nrd, nwr;
    if (!rst_n) begin
      m[k].rd = 0; m[k].wr = 0; m[k].fl = '0; m[k].first = 15;
      m[k].run_a = 0; m[k].run_r = 0; m[k].run_w = 0;
      m[k].p_req = 0; m[k].p_aack = 0; m[k].p_rnw = 0;
      m[k].p_addr = '0; m[k].p_wdata = '0; m[k].hist = 0;
      return;
    end
    racc = tc_req && tc_aack && tc_rnw;
    wacc = tc_req && tc_aack && !tc_rnw;
    e    = '0;
    ovf  = (racc || wacc) && (m[k].rd + m[k].wr == MAXO) && !tc_rack && !tc_wack;
    e[0] = ovf;
    e[1] = tc_rack && (m[k].rd == 0) && !(same[k] && racc);
    e[2] = tc_wack && (m[k].wr == 0) && !wacc;
    stall = m[k].hist && m[k].p_req && !m[k].p_aack;
    if (stall) begin
      e[3] = !tc_req;
      e[4] = (tc_addr != m[k].p_addr);
      e[5] = (tc_rnw != m[k].p_rnw);
      e[6] = !m[k].p_rnw && (tc_wdata != m[k].p_wdata);
    end
    m[k].run_a = (tc_req && !tc_aack)      ? m[k].run_a + 1 : 0;
    m[k].run_r = (m[k].rd > 0 && !tc_rack) ? m[k].run_r + 1 : 0;
    m[k].run_w = (m[k].wr > 0 && !tc_wack) ? m[k].run_w + 1 : 0;
    if (m[k].run_a == tmo[k]) e[7] = 1'b1;
    if (m[k].run_r == tmo[k] || m[k].run_w == tmo[k]) e[8] = 1'b1;
    nrd = m[k].rd;
    if (racc && !tc_rack) begin
      if (!ovf && m[k].rd < MAXO) nrd++;
    end else if (!racc && tc_rack && m[k].rd > 0) nrd--;
    nwr = m[k].wr;
    if (wacc && !tc_wack) begin
      if (!ovf && m[k].wr < MAXO) nwr++;
    end else if (!wacc && tc_wack && m[k].wr > 0) nwr--;
    m[k].rd = nrd;
    m[k].wr = nwr;
    if (err_clr) begin
      m[k].fl    = e;
      m[k].first = lowest(e);
    end else begin
      if (m[k].fl == 0 && e != 0) m[k].first = lowest(e);
      m[k].fl = m[k].fl | e;
    end
    m[k].p_req = tc_req; m[k].p_aack = tc_aack; m[k].p_rnw = tc_rnw;
    m[k].p_addr = tc_addr; m[k].p_wdata = tc_wdata; m[k].hist = 1'b1;
  endtask

  task automatic cmp(input string nm, input obs_t a, input obs_t e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got rd=%0d wr=%0d flags=%h first=%h irq=%0d, expected rd=%0d wr=%0d flags=%h first=%h irq=%0d",
               nm, a.rd, a.wr, a.fl, a.first, a.irq, e.rd, e.wr, e.fl, e.first, e.irq);
    end
  endtask

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // Monitor: one expected observation per clock edge per instance
  initial begin
    forever begin
      @(posedge clk_bus);
      #1;
      if (q0.size() > 0) cmp("sb_u0", dobs(0), q0.pop_front());
      if (q1.size() > 0) cmp("sb_u1", dobs(1), q1.pop_front());
    end
  end

  // Inputs are set at the falling edge; this call covers the next rising edge
  task automatic step();
    model_step(0);
    model_step(1);
    q0.push_back(mobs(0));
    q1.push_back(mobs(1));
    @(posedge clk_bus);
    @(negedge clk_bus);
  endtask

  task automatic idle_in();
    tc_req = 0; tc_aack = 0; tc_rack = 0; tc_wack = 0; err_clr = 0;
  endtask

  task automatic do_reset();
    idle_in();
    rst_n = 0;
    step();
    rst_n = 1;
  endtask

  initial begin
    @(negedge clk_bus);
    idle_in();
    step();
    chk("reset_rd", 16'(rd_p[0]), 16'd0);
    chk("reset_first", 16'(first[1]), 16'hF);
    rst_n = 1;

    // Read accepted, rack two cycles later
    tc_req = 1; tc_aack = 1; tc_rnw = 1; tc_addr = 8'h10;
    step();
    chk("rd_seq_1", 16'(rd_p[0]), 16'd1);
    idle_in();
    step();
    chk("rd_seq_2", 16'(rd_p[0]), 16'd1);
    tc_rack = 1;
    step();
    idle_in();
    chk("rd_seq_3", 16'(rd_p[0]), 16'd0);
    chk("rd_seq_flags", 16'(flags[0]), 16'd0);

    // Overflow on fifth write acceptance
    do_reset();
    tc_req = 1; tc_aack = 1; tc_rnw = 0;
    repeat (4) step();
    chk("ovf_wr4", 16'(wr_p[0]), 16'd4);
    step();
    idle_in();
    chk("ovf_wr", 16'(wr_p[0]), 16'd4);
    chk("ovf_flags", 16'(flags[0]), 16'h001);
    chk("ovf_first", 16'(first[0]), 16'd0);
    chk("ovf_irq", 16'(irq[0]), 16'd1);

    // Address changes while waiting for aack
    do_reset();
    tc_req = 1; tc_aack = 0; tc_rnw = 1; tc_addr = 8'h12;
    step();
    tc_addr = 8'h34;
    step();
    idle_in();
    chk("addr_chg_flags", 16'(flags[0]), 16'h010);
    chk("addr_chg_first", 16'(first[0]), 16'd4);

    // rack coinciding with read acceptance
    do_reset();
    tc_req = 1; tc_aack = 1; tc_rnw = 1; tc_rack = 1;
    step();
    idle_in();
    chk("same_cyc_u0_flags", 16'(flags[0]), 16'h002);
    chk("same_cyc_u1_flags", 16'(flags[1]), 16'h000);
    chk("same_cyc_u1_rd", 16'(rd_p[1]), 16'd0);

    // Response timeout on the TIMEOUT=4 instance
    do_reset();
    tc_req = 1; tc_aack = 1; tc_rnw = 1;
    step();
    idle_in();
    repeat (3) step();
    chk("tmo_early", 16'(flags[1]), 16'h000);
    step();
    chk("tmo_hit", 16'(flags[1]), 16'h100);
    err_clr = 1;
    step();
    err_clr = 0;
    chk("tmo_clr", 16'(flags[1]), 16'h000);
    chk("tmo_clr_first", 16'(first[1]), 16'hF);

    // Asynchronous reset with reads outstanding
    do_reset();
    tc_req = 1; tc_aack = 1; tc_rnw = 1;
    repeat (3) step();
    idle_in();
    chk("arst_pre", 16'(rd_p[0]), 16'd3);
    #2 rst_n = 0;
    #1;
    for (int k = 0; k < 2; k++) begin
      chk("arst_rd", 16'(rd_p[k]), 16'd0);
      chk("arst_wr", 16'(wr_p[k]), 16'd0);
      chk("arst_flags", 16'(flags[k]), 16'd0);
      chk("arst_first", 16'(first[k]), 16'hF);
      chk("arst_irq", 16'(irq[k]), 16'd0);
    end
    step();
    rst_n = 1;

    // Random traffic
    for (int n = 0; n < 800; n++) begin
      tc_req  = ($urandom_range(0, 9) < 6);
      tc_aack = ($urandom_range(0, 1) == 0);
      if ($urandom_range(0, 3) == 0) begin
        tc_addr  = 8'($urandom_range(0, 3));
        tc_rnw   = ($urandom_range(0, 1) == 0);
        tc_wdata = 8'($urandom_range(0, 3));
      end
      tc_rack = ($urandom_range(0, 4) == 0);
      tc_wack = ($urandom_range(0, 4) == 0);
      err_clr = ($urandom_range(0, 15) == 0);
      rst_n   = ($urandom_range(0, 199) != 0);
      step();
    end

    idle_in();
    rst_n = 1;
    step();
    step();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
